buzzer_melody_sequencer: RTL

- Programmable melody sequencer for the 8-buzzer notes bank: G6, F6, D6, B7, C6, A7, E6, C7.
- Holds a small step memory. Each step is a note code plus a duration.
- Plays the steps in order at a prescaled tempo, with a silent gap between notes. Optional looping.
- Sits between a host/control panel and the buzzer outputs. Drives at most one buzzer at a time.

---
 rtl/notes_pkg.sv | 54 +++++
 rtl/tick_prescaler.sv | 32 +++
 rtl/buzzer_melody_sequencer.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/notes_pkg.sv
// Shared note codes, buzzer bit positions, sequencer state and step record
// for the eight-buzzer melody sequencer.
package notes_pkg;

    localparam logic [3:0] NOTE_REST = 4'd0;
    localparam logic [3:0] NOTE_G6   = 4'd1;
    localparam logic [3:0] NOTE_F6   = 4'd2;
    localparam logic [3:0] NOTE_D6   = 4'd3;
    localparam logic [3:0] NOTE_B7   = 4'd4;
    localparam logic [3:0] NOTE_C6   = 4'd5;
    localparam logic [3:0] NOTE_A7   = 4'd6;
    localparam logic [3:0] NOTE_E6   = 4'd7;
    localparam logic [3:0] NOTE_C7   = 4'd8;

    localparam int BUZZ_G6 = 0;
    localparam int BUZZ_F6 = 1;
    localparam int BUZZ_D6 = 2;
    localparam int BUZZ_B7 = 3;
    localparam int BUZZ_C6 = 4;
    localparam int BUZZ_A7 = 5;
    localparam int BUZZ_E6 = 6;
    localparam int BUZZ_C7 = 7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_NOTE = 2'd2,
        ST_GAP  = 2'd3
    } seq_state_e;

    typedef struct packed {
        logic [3:0] note;
        logic [3:0] dur;
    } step_t;

    // Codes 0 and 9..15 are rests and drive no buzzer.
    function automatic logic [7:0] note_decode(input logic [3:0] code);
        logic [7:0] oh;
        oh = '0;
        case (code)
            NOTE_G6: oh[BUZZ_G6] = 1'b1;
            NOTE_F6: oh[BUZZ_F6] = 1'b1;
            NOTE_D6: oh[BUZZ_D6] = 1'b1;
            NOTE_B7: oh[BUZZ_B7] = 1'b1;
            NOTE_C6: oh[BUZZ_C6] = 1'b1;
            NOTE_A7: oh[BUZZ_A7] = 1'b1;
            NOTE_E6: oh[BUZZ_E6] = 1'b1;
            NOTE_C7: oh[BUZZ_C7] = 1'b1;
            default: oh = '0;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Tempo prescaler: pulses tick once every PRESCALE cycles while clear is low.
module tick_prescaler #(
    parameter int PRESCALE = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic tick
);
    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (clear || (cnt_q == CNT_LAST)) begin
            cnt_d = '0;
        end
    end

    assign tick = !clear && (cnt_q == CNT_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/buzzer_melody_sequencer.sv
// Programmable melody sequencer: plays (note, duration) steps from a small
// memory onto eight one-hot buzzer outputs with a silent gap between notes.
module buzzer_melody_sequencer
    import notes_pkg::*;
#(
    parameter int STEPS    = 16,
    parameter int PRESCALE = 1000,
    parameter int GAP      = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [$clog2(STEPS)-1:0] wr_addr,
    input  logic [3:0]               wr_note,
    input  logic [3:0]               wr_dur,
    input  logic [$clog2(STEPS):0]   len,
    input  logic                     start,
    input  logic                     stop,
    input  logic                     loop_en,
    output logic                     busy,
    output logic [$clog2(STEPS)-1:0] step_idx,
    output logic [7:0]               buzzer,
    output logic                     done
);
    localparam int AW       = $clog2(STEPS);
    localparam int LW       = AW + 1;
    localparam int GW       = $clog2(GAP + 2);
    localparam int GAP_LAST = (GAP > 0) ? GAP - 1 : 0;
    localparam logic [LW-1:0] LEN_MAX = LW'(STEPS);

    step_t         mem_q [STEPS];
    seq_state_e    state_q, state_d;
    logic [AW-1:0] step_idx_q, step_idx_d;
    logic [LW-1:0] len_q, len_d, len_eff;
    logic [3:0]    dur_q, dur_d;
    logic [3:0]    dur_cnt_q, dur_cnt_d;
    logic [GW-1:0] gap_cnt_q, gap_cnt_d;
    logic [7:0]    buzzer_q, buzzer_d;
    logic          done_q, done_d;
    logic          pre_clear, tick, step_end, last_step;
    step_t         fetch;

    assign len_eff   = (len > LEN_MAX) ? LEN_MAX : len;
    assign last_step = ({1'b0, step_idx_q} == (len_q - LW'(1)));
    assign fetch     = mem_q[step_idx_q];

    tick_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (pre_clear),
        .tick  (tick)
    );

    // A LOAD in the same cycle as a write to that address sees the old entry.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < STEPS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en) begin
            mem_q[wr_addr] <= '{note: wr_note, dur: wr_dur};
        end
    end

    always_comb begin
        state_d    = state_q;
        step_idx_d = step_idx_q;
        len_d      = len_q;
        dur_d      = dur_q;
        dur_cnt_d  = dur_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        buzzer_d   = buzzer_q;
        done_d     = 1'b0;
        pre_clear  = 1'b1;
        step_end   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start && !stop) begin
                    if (len_eff != '0) begin
                        len_d      = len_eff;
                        step_idx_d = '0;
                        state_d    = ST_LOAD;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            ST_LOAD: begin
                dur_d     = fetch.dur;
                buzzer_d  = note_decode(fetch.note);
                dur_cnt_d = '0;
                gap_cnt_d = '0;
                state_d   = ST_NOTE;
            end
            ST_NOTE: begin
                pre_clear = 1'b0;
                if (tick) begin
                    if (dur_cnt_q == dur_q) begin
                        buzzer_d = '0;
                        if (GAP == 0) begin
                            step_end = 1'b1;
                        end else begin
                            state_d = ST_GAP;
                        end
                    end else begin
                        dur_cnt_d = dur_cnt_q + 4'd1;
                    end
                end
            end
            ST_GAP: begin
                gap_cnt_d = gap_cnt_q + GW'(1);
                if (gap_cnt_q == GW'(GAP_LAST)) begin
                    step_end = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // loop_en is looked at only when the last step finishes.
        if (step_end) begin
            gap_cnt_d = '0;
            if (!last_step) begin
                step_idx_d = step_idx_q + AW'(1);
                state_d    = ST_LOAD;
            end else if (loop_en) begin
                step_idx_d = '0;
                state_d    = ST_LOAD;
            end else begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
            end
        end

        if (stop && (state_q != ST_IDLE)) begin
            state_d  = ST_IDLE;
            buzzer_d = '0;
            done_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            step_idx_q <= '0;
            len_q      <= '0;
            dur_q      <= '0;
            dur_cnt_q  <= '0;
            gap_cnt_q  <= '0;
            buzzer_q   <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            step_idx_q <= step_idx_d;
            len_q      <= len_d;
            dur_q      <= dur_d;
            dur_cnt_q  <= dur_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            buzzer_q   <= buzzer_d;
            done_q     <= done_d;
        end
    end

    assign busy     = (state_q != ST_IDLE);
    assign step_idx = step_idx_q;
    assign buzzer   = buzzer_q;
    assign done     = done_q;

endmodule
